// File: rtl/disk_host_pkg.sv
// Shared definitions for the host disk channel: sr/cr bit positions,
// arbiter state encoding and the client request decode.
package disk_host_pkg;

  localparam int SR_ACK   = 16;
  localparam int SR_RD0   = 17;
  localparam int SR_RD1   = 18;
  localparam int SR_WR0   = 20;
  localparam int SR_WR1   = 21;
  localparam int SR_SEEK0 = 24;
  localparam int SR_SEEK1 = 25;
  localparam int CR_DONE  = 4;
  localparam int CR_ERR   = 3;

  typedef enum logic [3:0] {
    ARB_IDLE  = 4'b0001,
    ARB_BUSY  = 4'b0010,
    ARB_ACK   = 4'b0100,
    ARB_DRAIN = 4'b1000
  } arb_state_e;

  // A client wants the channel when any seek, write or read bit is set.
  function automatic logic sr_req(input logic [31:0] sr);
    return sr[SR_SEEK1] | sr[SR_SEEK0] | sr[SR_WR1] | sr[SR_WR0] |
           sr[SR_RD1]   | sr[SR_RD0];
  endfunction

endpackage

// File: rtl/disk_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, on contention the
// client that did not own the channel last wins.
module disk_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = 2'b00;
    case (req_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      2'b11:   winner_o = last_owner_i ? 2'b01 : 2'b10;
      default: winner_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/disk_host_arbiter.sv
// Shares the host disk channel between two controllers, one whole
// transaction at a time. Define ARB_TIMEOUT_EN to add a BUSY watchdog.
module disk_host_arbiter
  import disk_host_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c0_sr,
  output logic [31:0] c0_cr,
  input  logic [7:0]  c0_data_out,
  output logic [7:0]  c0_data_in,
  output logic        c0_clkout,
  output logic        c0_clkin,
  input  logic [31:0] c1_sr,
  output logic [31:0] c1_cr,
  input  logic [7:0]  c1_data_out,
  output logic [7:0]  c1_data_in,
  output logic        c1_clkout,
  output logic        c1_clkin,
  output logic [31:0] host_sr,
  input  logic [31:0] host_cr,
  input  logic [7:0]  host_data_in,
  output logic [7:0]  host_data_out,
  input  logic        host_clkin,
  input  logic        host_clkout,
  output logic [1:0]  grant
);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] host_sr_q, host_sr_d;
  logic [1:0]  req, winner;
  logic [31:0] owner_sr;
  logic        owner_req;
  logic        timeout_hit;
  logic        forced;

  assign req       = {sr_req(c1_sr), sr_req(c0_sr)};
  assign owner_sr  = grant_q[1] ? c1_sr : c0_sr;
  assign owner_req = sr_req(owner_sr);

  disk_rr_pick u_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .winner_o     (winner)
  );

`ifdef ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        forced_q, forced_d;

  assign timeout_hit = (state_q == ARB_BUSY) && (cnt_q == TIMEOUT_CYCLES - 24'd1);
  assign forced      = forced_q;

  // Forced done/error lasts only while the owner has not yet acknowledged.
  always_comb begin
    cnt_d    = (state_d != state_q || state_q != ARB_BUSY) ? 24'd0 : cnt_q + 24'd1;
    forced_d = (state_d == ARB_ACK) &&
               (forced_q || (timeout_hit && !host_cr[CR_DONE]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 24'd0;
      forced_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign forced         = 1'b0;
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      host_sr_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      host_sr_q    <= host_sr_d;
    end
  end

  // NOTE: defaults first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    host_sr_d    = host_sr_q;
    case (state_q)
      ARB_IDLE: begin
        host_sr_d = 32'd0;
        if (|req) begin
          state_d      = ARB_BUSY;
          grant_d      = winner;
          last_owner_d = winner[1];
          host_sr_d    = winner[1] ? c1_sr : c0_sr;
        end
      end
      ARB_BUSY: begin
        host_sr_d = owner_sr;
        if (host_cr[CR_DONE] || timeout_hit) state_d = ARB_ACK;
      end
      ARB_ACK: begin
        host_sr_d = owner_sr;
        if (owner_sr[SR_ACK] && !owner_req) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!host_cr[CR_DONE]) begin
          state_d   = ARB_IDLE;
          grant_d   = 2'b00;
          host_sr_d = 32'd0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        grant_d   = 2'b00;
        host_sr_d = 32'd0;
      end
    endcase
  end

  // grant_q is non-zero only in BUSY/ACK/DRAIN, so it alone gates flags and strobes.
  always_comb begin
    logic [1:0] flags;
    flags         = forced ? 2'b11 : host_cr[CR_DONE:CR_ERR];
    c0_cr         = {host_cr[31:5], grant_q[0] ? flags : 2'b00, host_cr[2:0]};
    c1_cr         = {host_cr[31:5], grant_q[1] ? flags : 2'b00, host_cr[2:0]};
    c0_data_in    = host_data_in;
    c1_data_in    = host_data_in;
    c0_clkin      = host_clkin  & grant_q[0];
    c1_clkin      = host_clkin  & grant_q[1];
    c0_clkout     = host_clkout & grant_q[0];
    c1_clkout     = host_clkout & grant_q[1];
    host_data_out = 8'h00;
    case (grant_q)
      2'b01:   host_data_out = c0_data_out;
      2'b10:   host_data_out = c1_data_out;
      default: host_data_out = 8'h00;
    endcase
  end

  assign host_sr = host_sr_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_disk_host_arbiter.sv
// Directed bench for disk_host_arbiter; covers the ARB_TIMEOUT_EN watchdog
// when that macro is defined, otherwise checks BUSY waits indefinitely.
module tb_disk_host_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] c0_sr = '0, c1_sr = '0, host_cr = '0;
  logic [7:0]  c0_data_out = '0, c1_data_out = '0, host_data_in = '0;
  logic        host_clkin = 1'b0, host_clkout = 1'b0;
  logic [31:0] c0_cr, c1_cr, host_sr;
  logic [7:0]  c0_data_in, c1_data_in, host_data_out;
  logic        c0_clkout, c0_clkin, c1_clkout, c1_clkin;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;
  int c0_in_n = 0, c1_in_n = 0, c0_out_n = 0, c1_out_n = 0;
  int mism;
  int n;

  disk_host_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .rst(rst),
    .c0_sr(c0_sr), .c0_cr(c0_cr), .c0_data_out(c0_data_out), .c0_data_in(c0_data_in),
    .c0_clkout(c0_clkout), .c0_clkin(c0_clkin),
    .c1_sr(c1_sr), .c1_cr(c1_cr), .c1_data_out(c1_data_out), .c1_data_in(c1_data_in),
    .c1_clkout(c1_clkout), .c1_clkin(c1_clkin),
    .host_sr(host_sr), .host_cr(host_cr), .host_data_in(host_data_in),
    .host_data_out(host_data_out), .host_clkin(host_clkin), .host_clkout(host_clkout),
    .grant(grant)
  );

  always #5 clk = ~clk;

  always @(posedge c0_clkin)  c0_in_n++;
  always @(posedge c1_clkin)  c1_in_n++;
  always @(posedge c0_clkout) c0_out_n++;
  always @(posedge c1_clkout) c1_out_n++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host done, owner acks, host drops done: returns to IDLE.
  task automatic finish_txn(input int owner);
    host_cr = host_cr | 32'h10;
    tick();
    if (owner == 0) c0_sr = 32'h0001_0000;
    else            c1_sr = 32'h0001_0000;
    tick();
    host_cr = host_cr & ~32'h10;
    tick();
    if (owner == 0) c0_sr = '0;
    else            c1_sr = '0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_grant",   {30'd0, grant}, 32'd0);
    check("reset_host_sr", host_sr, 32'd0);
    check("reset_c0_cr",   c0_cr, 32'd0);
    check("reset_clkin",   {31'd0, c0_clkin}, 32'd0);

    // Client 0 read alone
    c0_sr = 32'h0002_0000;
    tick();
    check("rd_grant",   {30'd0, grant}, 32'd1);
    check("rd_host_sr", host_sr, 32'h0002_0000);
    host_data_in = 8'h5A;
    #1;
    check("rd_c0_data_in", {24'd0, c0_data_in}, 32'h5A);
    check("rd_c1_data_in", {24'd0, c1_data_in}, 32'h5A);
    for (int i = 0; i < 512; i++) begin
      host_clkin = 1'b1;
      #2;
      host_clkin = 1'b0;
      tick();
    end
    check("rd_c0_clkin_cnt", c0_in_n, 512);
    check("rd_c1_clkin_cnt", c1_in_n, 0);
    host_cr = 32'h10;
    #1;
    check("rd_done_c0", c0_cr, 32'h10);
    check("rd_done_c1", c1_cr, 32'h0);
    tick();
    c0_sr = 32'h0001_0000;
    tick();
    check("rd_drain_sr",    host_sr, 32'h0001_0000);
    check("rd_drain_grant", {30'd0, grant}, 32'd1);
    host_cr = '0;
    tick();
    check("rd_idle_grant", {30'd0, grant}, 32'd0);
    check("rd_idle_sr",    host_sr, 32'd0);
    c0_sr = '0;

    // Contention after reset: client 0 first, then client 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c0_sr = 32'h0010_0000;
    c1_sr = 32'h0100_0000;
    tick();
    check("ct1_grant",   {30'd0, grant}, 32'd1);
    check("ct1_host_sr", host_sr, 32'h0010_0000);
    host_cr = 32'h10;
    #1;
    check("ct1_c0_done", c0_cr, 32'h10);
    check("ct1_c1_nodone", c1_cr, 32'h0);
    tick();
    c0_sr = 32'h0001_0000;
    tick();
    host_cr = '0;
    tick();
    c0_sr = '0;
    check("ct1_idle", {30'd0, grant}, 32'd0);
    tick();
    check("ct1_c1_grant",   {30'd0, grant}, 32'd2);
    check("ct1_c1_host_sr", host_sr, 32'h0100_0000);
    finish_txn(1);

    // Second contention: client 0 wins again since client 1 owned last
    c0_sr = 32'h0004_0000;
    c1_sr = 32'h0020_0000;
    tick();
    check("ct2_grant", {30'd0, grant}, 32'd1);
    finish_txn(0);
    tick();
    check("ct2_c1_grant", {30'd0, grant}, 32'd2);

    // Client 1 write
    c0_data_out = 8'hAA;
    mism = 0;
    c0_out_n = 0;
    c1_out_n = 0;
    for (int i = 0; i < 512; i++) begin
      c1_data_out = i[7:0];
      host_clkout = 1'b1;
      #1;
      if (host_data_out !== i[7:0]) mism++;
      #1;
      host_clkout = 1'b0;
      tick();
    end
    check("wr_data_mism",    mism, 0);
    check("wr_c1_clkout_cnt", c1_out_n, 512);
    check("wr_c0_clkout_cnt", c0_out_n, 0);

    // Completion with error, bit 5 status visible to both
    host_cr = 32'h38;
    #1;
    check("err_c1_cr", c1_cr, 32'h38);
    check("err_c0_cr", c0_cr, 32'h20);
    tick();
    c1_sr = 32'h0001_0000;
    tick();
    check("err_drain_c0_cr", c0_cr, 32'h20);
    check("err_drain_c1_cr", c1_cr, 32'h38);
    check("err_drain_sr",    host_sr, 32'h0001_0000);
    host_cr = 32'h20;
    tick();
    check("err_idle_grant", {30'd0, grant}, 32'd0);
    check("err_idle_c1_cr", c1_cr, 32'h20);
    c1_sr = '0;
    host_cr = '0;

    // Reset while BUSY, pending request re-granted
    c0_sr = 32'h0002_0000;
    tick();
    check("rb_grant", {30'd0, grant}, 32'd1);
    rst = 1'b1;
    tick();
    check("rb_rst_grant", {30'd0, grant}, 32'd0);
    check("rb_rst_sr",    host_sr, 32'd0);
    rst = 1'b0;
    tick();
    check("rb_regrant",    {30'd0, grant}, 32'd1);
    check("rb_regrant_sr", host_sr, 32'h0002_0000);
    finish_txn(0);

    // Owner withdraws in BUSY; new request coincident with DRAIN->IDLE
    c1_sr = 32'h0200_0000;
    tick();
    check("wd_grant", {30'd0, grant}, 32'd2);
    c1_sr = '0;
    tick();
    tick();
    check("wd_still_busy", {30'd0, grant}, 32'd2);
    check("wd_host_sr",    host_sr, 32'd0);
    host_cr = 32'h10;
    tick();
    c1_sr = 32'h0001_0000;
    tick();
    check("wd_drain", {30'd0, grant}, 32'd2);
    host_cr = '0;
    c0_sr = 32'h0002_0000;
    tick();
    check("late_req_idle", {30'd0, grant}, 32'd0);
    tick();
    check("late_req_grant", {30'd0, grant}, 32'd1);
    c1_sr = '0;
    finish_txn(0);

    // READ_ID toggle alone does not request
    c1_sr = 32'h0040_0000;
    tick();
    tick();
    check("rid_grant",   {30'd0, grant}, 32'd0);
    check("rid_host_sr", host_sr, 32'd0);
    c1_sr = '0;

    // Silent host
    c1_sr = 32'h0002_0000;
    tick();
    check("to_grant", {30'd0, grant}, 32'd2);
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (c1_cr[4:3] !== 2'b11 && n < 300) begin
      tick();
      n++;
    end
    check("to_cycles",   n, 100);
    check("to_c1_cr",    c1_cr, 32'h18);
    check("to_c0_cr",    c0_cr, 32'h0);
    c1_sr = 32'h0001_0000;
    tick();
    tick();
    check("to_idle", {30'd0, grant}, 32'd0);
    c1_sr = '0;
`else
    repeat (200) tick();
    check("nto_busy",  {30'd0, grant}, 32'd2);
    check("nto_c1_cr", c1_cr, 32'h0);
    finish_txn(1);
    check("nto_idle", {30'd0, grant}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
